// File: rtl/posit_pkg.sv
// Shared constants and helpers for the posit-to-float converter.
//   Default widths N_DEF/E_DEF/ES_DEF, flag bit indices, constant helpers
//   for log2, float exponent bias, canonical qNaN and infinity patterns.
package posit_pkg;

   localparam int unsigned N_DEF  = 16;
   localparam int unsigned E_DEF  = 5;
   localparam int unsigned ES_DEF = 2;

   // out_flags bit positions
   localparam int unsigned FLAG_OVF = 2;
   localparam int unsigned FLAG_UNF = 1;
   localparam int unsigned FLAG_INX = 0;

   // ceil(log2(v))
   function automatic int unsigned clog2_f(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((32'd1 << i) < v) r = 32'(i + 1);
      return r;
   endfunction

   // Float exponent bias 2^(E-1)-1
   function automatic int unsigned bias_f(input int unsigned e);
      return (32'd1 << (e - 1)) - 32'd1;
   endfunction

   // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in 64 bits
   function automatic logic [63:0] nan_fp(input int unsigned n, input int unsigned e);
      return (((64'd1 << e) - 64'd1) << (n - 1 - e)) | (64'd1 << (n - 2 - e));
   endfunction

   // Signed infinity {s, all-ones, 0...}, right-aligned in 64 bits
   function automatic logic [63:0] inf_fp(input int unsigned n, input int unsigned e,
                                          input logic s);
      return (64'(s) << (n - 1)) | (((64'd1 << e) - 64'd1) << (n - 1 - e));
   endfunction

endpackage

// File: rtl/posit_regime_cnt.sv
// Leading-run counter for the posit regime field.
//   word : W-bit field following the sign bit
//   run  : number of leading bits equal to word[W-1] (W when the whole field is one run)
//   pol  : run polarity (1 = run of ones)
module posit_regime_cnt
   import posit_pkg::*;
#(
   parameter int unsigned W  = 15,
   parameter int unsigned RW = clog2_f(W + 1)
) (
   input  logic [W-1:0]  word,
   output logic [RW-1:0] run,
   output logic          pol
);

   logic done;

   // Count from the MSB until the first bit that breaks the run
   always_comb begin
      pol  = word[W-1];
      run  = '0;
      done = 1'b0;
      for (int i = int'(W) - 1; i >= 0; i--) begin
         if (!done && (word[i] == pol)) run = run + RW'(1);
         else                           done = 1'b1;
      end
   end

endmodule

// File: rtl/posit_to_fp_pipe.sv
// Three-stage posit(N,es) to float(N,E) converter with valid/ready stream.
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_posit   : posit input stream
//   out_valid/out_ready/out_fp   : float output stream {sign, exp, mant}
//   out_flags                    : {overflow, underflow, inexact}
// Define POSIT2FP_SUBNORM_EN to produce subnormals; otherwise tiny results
// flush to signed zero and the denormalizing shifter is not built.
module posit_to_fp_pipe
   import posit_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned E  = E_DEF,
   parameter int unsigned ES = ES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_posit,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_fp,
   output logic [2:0]   out_flags
);

   localparam int unsigned M     = N - E - 1;
   localparam int unsigned RUN_W = clog2_f(N);
   localparam int unsigned SC_W  = clog2_f(N) + ES + 2;
   localparam int unsigned BX_W  = SC_W + 1;
   localparam int unsigned FR_W  = N - 1 - ES;
   // Low padding deep enough that a maximal shift lands every bit in sticky
   localparam int unsigned PAD   = M + 2;
   // Significand after denormalization, integer bit dropped
   localparam int unsigned EXT_W = FR_W + PAD;
   localparam logic signed [BX_W-1:0] BIAS_X  = BX_W'(bias_f(E));
   localparam logic signed [BX_W-1:0] EXP_TOP = BX_W'((1 << E) - 1);
   localparam logic [N-1:0] QNAN    = N'(nan_fp(N, E));
   localparam logic [N-1:0] INF_POS = N'(inf_fp(N, E, 1'b0));

   logic v1, v2, v3;
   logic ld1, ld2, ld3;

   // Stage 1 regs
   logic             s1_sign, s1_zero, s1_nar, s1_pol;
   logic [N-2:0]     s1_body;
   logic [RUN_W-1:0] s1_run;
   // Stage 2 regs
   logic                   s2_sign, s2_zero, s2_nar;
   logic signed [SC_W-1:0] s2_scale;
   logic [FR_W-1:0]        s2_frac;

   // Handshake: a stage loads when its successor is empty or moving on
   always_comb begin
      ld3      = v2 & (~v3 | out_ready);
      ld2      = v1 & (~v2 | ld3);
      in_ready = ~v1 | ld2;
      ld1      = in_valid & in_ready;
   end

   assign out_valid = v3;

   // Stage 1: magnitude and regime run
   logic [N-2:0]     body_c;
   logic [RUN_W-1:0] run_c;
   logic             pol_c;

   assign body_c = in_posit[N-1] ? (N-1)'(-in_posit) : in_posit[N-2:0];

   posit_regime_cnt #(.W(N - 1), .RW(RUN_W)) u_regime (
      .word (body_c),
      .run  (run_c),
      .pol  (pol_c)
   );

   // Stage 2: strip regime and terminator, form scale and fraction
   logic [N-2:0]           rest_c;
   logic [ES-1:0]          e_c;
   logic signed [SC_W-1:0] k_c, scale_c;

   always_comb begin
      rest_c  = (s1_body << s1_run) << 1;
      e_c     = rest_c[N-2 -: ES];
      k_c     = s1_pol ? $signed(SC_W'(s1_run)) - SC_W'(1) : -$signed(SC_W'(s1_run));
      scale_c = (k_c <<< ES) + $signed(SC_W'(e_c));
   end

   // Stage 3: rebias, denormalize, round to nearest even, map specials
   logic signed [BX_W-1:0] biased_c;
   logic                   ovf_rng_c, sub_rng_c;
   logic [EXT_W-1:0]       ext_c;
   logic [M-1:0]           mant_c;
   logic                   guard_c, sticky_c, rnd_c, inx_c;
   logic [M:0]             mant_r_c;
   logic [E:0]             exp_r_c;
   logic [N-1:0]           fp_c;
   logic [2:0]             flags_c;
`ifdef POSIT2FP_SUBNORM_EN
   localparam int unsigned SH_W = clog2_f(PAD + 1);
   logic signed [BX_W-1:0] sh_full_c;
   logic [SH_W-1:0]        sh_c;
`endif

   always_comb begin
      biased_c  = BX_W'(s2_scale) + BIAS_X;
      ovf_rng_c = (biased_c >= EXP_TOP);
      sub_rng_c = (biased_c < BX_W'(1));
`ifdef POSIT2FP_SUBNORM_EN
      sh_full_c = BX_W'(1) - biased_c;
      if (!sub_rng_c)                           sh_c = '0;
      else if (sh_full_c > $signed(BX_W'(PAD))) sh_c = SH_W'(PAD);
      else                                      sh_c = SH_W'(sh_full_c);
      ext_c = EXT_W'({1'b1, s2_frac, {PAD{1'b0}}} >> sh_c);
`else
      ext_c = {s2_frac, {PAD{1'b0}}};
`endif
      mant_c   = ext_c[EXT_W-1 -: M];
      guard_c  = ext_c[EXT_W-1-M];
      sticky_c = |ext_c[EXT_W-2-M:0];
      rnd_c    = guard_c & (sticky_c | mant_c[0]);
      inx_c    = guard_c | sticky_c;
      mant_r_c = {1'b0, mant_c} + (M+1)'(rnd_c);
      // Mantissa carry bumps the exponent; a subnormal carry becomes the min normal
      exp_r_c  = (sub_rng_c ? '0 : {1'b0, biased_c[E-1:0]}) + (E+1)'(mant_r_c[M]);

      fp_c              = {s2_sign, exp_r_c[E-1:0], mant_r_c[M-1:0]};
      flags_c           = '0;
      flags_c[FLAG_INX] = inx_c;
      flags_c[FLAG_UNF] = sub_rng_c & inx_c;

      if (s2_nar) begin
         fp_c    = QNAN;
         flags_c = '0;
      end else if (s2_zero) begin
         fp_c    = '0;
         flags_c = '0;
      end else if (ovf_rng_c || (exp_r_c >= (E+1)'((1 << E) - 1))) begin
         fp_c              = {s2_sign, INF_POS[N-2:0]};
         flags_c           = '0;
         flags_c[FLAG_OVF] = 1'b1;
         flags_c[FLAG_INX] = 1'b1;
`ifndef POSIT2FP_SUBNORM_EN
      end else if (sub_rng_c) begin
         fp_c              = {s2_sign, {(N-1){1'b0}}};
         flags_c           = '0;
         flags_c[FLAG_UNF] = 1'b1;
         flags_c[FLAG_INX] = 1'b1;
`endif
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         s1_sign   <= 1'b0;
         s1_zero   <= 1'b0;
         s1_nar    <= 1'b0;
         s1_pol    <= 1'b0;
         s1_body   <= '0;
         s1_run    <= '0;
         s2_sign   <= 1'b0;
         s2_zero   <= 1'b0;
         s2_nar    <= 1'b0;
         s2_scale  <= '0;
         s2_frac   <= '0;
         out_fp    <= '0;
         out_flags <= '0;
      end else begin
         v1 <= ld1 | (v1 & ~ld2);
         v2 <= ld2 | (v2 & ~ld3);
         v3 <= ld3 | (v3 & ~out_ready);
         if (ld1) begin
            s1_sign <= in_posit[N-1];
            s1_zero <= (in_posit == '0);
            s1_nar  <= (in_posit == {1'b1, {(N-1){1'b0}}});
            s1_pol  <= pol_c;
            s1_body <= body_c;
            s1_run  <= run_c;
         end
         if (ld2) begin
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_nar   <= s1_nar;
            s2_scale <= scale_c;
            s2_frac  <= rest_c[FR_W-1:0];
         end
         if (ld3) begin
            out_fp    <= fp_c;
            out_flags <= flags_c;
         end
      end
   end

endmodule

// File: tb/tb_posit_to_fp_pipe.sv
// Directed bench for posit_to_fp_pipe (posit16,es=2 -> half float).
// Expected values for tiny results follow POSIT2FP_SUBNORM_EN.
`timescale 1ns/1ps
module tb_posit_to_fp_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_posit;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_fp;
   logic [2:0]  out_flags;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   posit_to_fp_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_posit  (in_posit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fp    (out_fp),
      .out_flags (out_flags)
   );

`ifdef POSIT2FP_SUBNORM_EN
   localparam logic [15:0] FP_0400 = 16'h0100;
   localparam logic [2:0]  FL_0400 = 3'b000;
   localparam logic [15:0] FP_0500 = 16'h0200;
   localparam logic [2:0]  FL_0500 = 3'b000;
`else
   localparam logic [15:0] FP_0400 = 16'h0000;
   localparam logic [2:0]  FL_0400 = 3'b011;
   localparam logic [15:0] FP_0500 = 16'h0000;
   localparam logic [2:0]  FL_0500 = 3'b011;
`endif

   localparam int NV = 19;
   logic [15:0] vp [NV];
   logic [15:0] vf [NV];
   logic [2:0]  vl [NV];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One word through an empty pipe: valid exactly 3 cycles after acceptance
   task automatic convert(input logic [15:0] p, input logic [15:0] efp,
                          input logic [2:0] efl, input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_posit  = p;
      #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_posit = '0;
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_fp"},    32'(out_fp),    32'(efp));
      chk({tag, "_flags"}, 32'(out_flags), 32'(efl));
      @(negedge clk);
      chk({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int idx_list [8];
      int exp_q [$];
      int sent, recv, occ;
      logic acc, rel;

      // 0xFFFF is -minpos (tiny, negative); 0x8001 is -maxpos (overflows)
      vp = '{16'h4000, 16'hC000, 16'h4800, 16'hB800, 16'h3000, 16'h0000, 16'h8000,
             16'h7FFF, 16'h8001, 16'h4001, 16'h4003, 16'h7B00, 16'h7BFF, 16'h7C00,
             16'h0600, 16'h0400, 16'h0500, 16'h0001, 16'hFFFF};
      vf = '{16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 16'h3400, 16'h0000, 16'h7E00,
             16'h7C00, 16'hFC00, 16'h3C00, 16'h3C02, 16'h7800, 16'h7BFC, 16'h7C00,
             16'h0400, FP_0400, FP_0500, 16'h0000, 16'h8000};
      vl = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b101, 3'b101, 3'b001, 3'b001, 3'b000, 3'b000, 3'b101,
             3'b000, FL_0400, FL_0500, 3'b011, 3'b011};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_posit  = '0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_fp",    32'(out_fp),    32'd0);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed conversions
      for (int i = 0; i < NV; i++)
         convert(vp[i], vf[i], vl[i], $sformatf("v%0d_%h", i, vp[i]));

      // Backpressured stream of table entries, checked in order
      for (int i = 0; i < 8; i++) idx_list[i] = $urandom_range(0, NV - 1);
      sent = 0;
      recv = 0;
      occ  = 0;
      for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
         @(negedge clk);
         out_ready = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
         in_valid  = (sent < 8) && ((cyc < 6) || ($urandom_range(0, 3) != 0));
         in_posit  = (sent < 8) ? vp[idx_list[sent]] : 16'h0000;
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'(!((occ == 3) && !out_ready)));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("bp_spurious_valid", 32'(out_valid), 32'd0);
            end else begin
               chk("bp_fp",    32'(out_fp),    32'(vf[exp_q[0]]));
               chk("bp_flags", 32'(out_flags), 32'(vl[exp_q[0]]));
            end
         end
         acc = in_valid && in_ready;
         rel = out_valid && out_ready;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(idx_list[sent]);
            sent++;
         end
         if (rel && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            recv++;
         end
         occ = occ + int'(acc) - int'(rel);
      end
      chk("bp_words_received", 32'(recv), 32'd8);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Reset with two words in flight
      @(negedge clk);
      in_valid = 1'b1;
      in_posit = 16'h4000;
      @(negedge clk);
      in_posit = 16'h4800;
      @(negedge clk);
      in_valid = 1'b0;
      in_posit = '0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_fp",    32'(out_fp),    32'd0);
      @(negedge clk);
      chk("mid_rst_next_cycle", 32'(out_valid), 32'd0);
      rst = 1'b0;
      #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stale_output", 32'(out_valid), 32'd0);
      end
      convert(16'hC000, 16'hBC00, 3'b000, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
